// File: rtl/pe_row_pkg.sv
// Shared types and default geometry for the parametrised PE row.
package pe_row_pkg;

    // Pixel routing mode, sampled together with each input beat
    typedef enum logic [1:0] {
        DIRECT     = 2'd0,
        CAST       = 2'd1,
        SHIFT      = 2'd2,
        CAST_SHIFT = 2'd3
    } pe_mode_e;

    localparam int DEF_NUM_PE    = 16;
    localparam int DEF_DW        = 8;
    localparam int DEF_PW        = 16;
    localparam int DEF_ACC_W     = 24;
    localparam int DEF_CAST_BASE = 12;
    localparam int DEF_CAST_NUM  = 3;

endpackage

// File: rtl/pe_row_if.sv
// Beat/bus bundle between the pixel/weight buffers, the PE row and the adder tree.
interface pe_row_if
    import pe_row_pkg::*;
#(
    parameter int NUM_PE   = DEF_NUM_PE,
    parameter int DW       = DEF_DW,
    parameter int PW       = DEF_PW,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int CAST_NUM = DEF_CAST_NUM
);
    logic [1:0]                   mode;
    logic                         in_valid;
    logic [NUM_PE-1:0][DW-1:0]    pixel_in;
    logic [CAST_NUM-1:0][DW-1:0]  pixel_cast;
    logic                         w_load;
    logic [NUM_PE-1:0][DW-1:0]    weight_in;
    logic                         acc_clr;

    logic [NUM_PE-1:0][DW-1:0]    next_pixel;
    logic                         prod_valid;
    logic [NUM_PE-1:0][PW-1:0]    product;
    logic                         acc_valid;
    logic [NUM_PE-1:0][ACC_W-1:0] acc_out;
    logic [NUM_PE-1:0]            acc_sat;

    modport master (
        output mode, in_valid, pixel_in, pixel_cast, w_load, weight_in, acc_clr,
        input  next_pixel, prod_valid, product, acc_valid, acc_out, acc_sat
    );

    modport slave (
        input  mode, in_valid, pixel_in, pixel_cast, w_load, weight_in, acc_clr,
        output next_pixel, prod_valid, product, acc_valid, acc_out, acc_sat
    );
endinterface

// File: rtl/pe_lane.sv
// One weight-stationary MAC lane: pixel/weight capture, multiply, saturating accumulate.
module pe_lane
    import pe_row_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int PW    = DEF_PW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_valid,
    input  logic [DW-1:0]    sel_pixel,
    input  logic             w_load,
    input  logic [DW-1:0]    weight_in,
    input  logic             vld_p1,
    input  logic             vld_p2,
    input  logic             clr_p2,
    output logic [DW-1:0]    next_pixel,
    output logic [PW-1:0]    product,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_sat
);

    // MSB of the result is the overflow flag, the rest the clamped sum
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PW-1:0]    b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-PW){b[PW-1]}}, b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W])
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            else
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    logic signed [DW-1:0]    weight_q;
    logic        [DW-1:0]    pix_p1;
    logic signed [DW-1:0]    weight_p1;
    logic signed [PW-1:0]    prod_p2;
    logic        [ACC_W-1:0] acc_p3;
    logic                    sat_p3;

    logic        [PW-1:0]    pix_ext;
    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    mult;
    logic        [ACC_W:0]   acc_nxt;

    // Pixel is unsigned, weight signed; the exact product always fits PW bits
    assign pix_ext = PW'(pix_p1);
    assign w_ext   = PW'(weight_p1);
    assign mult    = $signed(pix_ext) * w_ext;
    assign acc_nxt = sat_add(clr_p2 ? '0 : acc_p3, prod_p2);

    // Stationary weight register; a beat in the same cycle still sees the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        weight_q <= '0;
        else if (w_load) weight_q <= weight_in;
    end

    // ---- stage 1: capture routed pixel and the beat's weight ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_p1    <= '0;
            weight_p1 <= '0;
        end else if (beat_valid) begin
            pix_p1    <= sel_pixel;
            weight_p1 <= weight_q;
        end
    end

    // ---- stage 2: register the product ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        prod_p2 <= '0;
        else if (vld_p1) prod_p2 <= mult;
    end

    // ---- stage 3: saturating accumulate; a clear beat also restarts the sticky flag ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_p3 <= '0;
            sat_p3 <= 1'b0;
        end else if (vld_p2) begin
            acc_p3 <= acc_nxt[ACC_W-1:0];
            sat_p3 <= (clr_p2 ? 1'b0 : sat_p3) | acc_nxt[ACC_W];
        end
    end

    assign next_pixel = pix_p1;
    assign product    = prod_p2;
    assign acc_out    = acc_p3;
    assign acc_sat    = sat_p3;

endmodule

// File: rtl/pe_row_param.sv
// Row of NUM_PE MAC lanes with run-time pixel routing and a valid-tagged pipeline.
module pe_row_param
    import pe_row_pkg::*;
#(
    parameter int NUM_PE    = DEF_NUM_PE,
    parameter int DW        = DEF_DW,
    parameter int PW        = DEF_PW,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CAST_BASE = DEF_CAST_BASE,
    parameter int CAST_NUM  = DEF_CAST_NUM
) (
    input  logic    clk,
    input  logic    rst,
    pe_row_if.slave bus
);

    pe_mode_e mode_sel;
    logic     vld_p1, clr_p1, vld_p2, clr_p2, vld_p3;

    logic [DW-1:0]    np     [NUM_PE];
    logic [PW-1:0]    prod_w [NUM_PE];
    logic [ACC_W-1:0] acc_w  [NUM_PE];
    logic             sat_w  [NUM_PE];

    assign mode_sel = pe_mode_e'(bus.mode);

    // ---- valid / clear tags travel one stage per clock alongside the lane data ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            clr_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            clr_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            clr_p1 <= bus.in_valid & bus.acc_clr;
            vld_p2 <= vld_p1;
            clr_p2 <= clr_p1;
            vld_p3 <= vld_p2;
        end
    end

    assign bus.prod_valid = vld_p2;
    assign bus.acc_valid  = vld_p3;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        localparam bit IS_CAST = (i >= CAST_BASE) && (i < CAST_BASE + CAST_NUM);

        logic [DW-1:0] shift_src;
        logic [DW-1:0] cast_src;
        logic [DW-1:0] sel_pixel;

        // Lane 0 heads the systolic chain; others take the neighbour's registered pixel
        if (i == 0) begin : g_head
            assign shift_src = bus.pixel_in[0];
        end else begin : g_chain
            assign shift_src = np[i-1];
        end

        // Non-cast lanes fall back to their own pixel when cast routing is selected
        if (IS_CAST) begin : g_cast
            assign cast_src = bus.pixel_cast[i-CAST_BASE];
        end else begin : g_plain
            assign cast_src = bus.pixel_in[i];
        end

        // Select this lane's pixel from the beat's mode
        always_comb begin
            sel_pixel = bus.pixel_in[i];
            case (mode_sel)
                CAST:       sel_pixel = cast_src;
                SHIFT:      sel_pixel = shift_src;
                CAST_SHIFT: sel_pixel = IS_CAST ? cast_src : shift_src;
                default:    sel_pixel = bus.pixel_in[i];
            endcase
        end

        pe_lane #(
            .DW    (DW),
            .PW    (PW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .beat_valid (bus.in_valid),
            .sel_pixel  (sel_pixel),
            .w_load     (bus.w_load),
            .weight_in  (bus.weight_in[i]),
            .vld_p1     (vld_p1),
            .vld_p2     (vld_p2),
            .clr_p2     (clr_p2),
            .next_pixel (np[i]),
            .product    (prod_w[i]),
            .acc_out    (acc_w[i]),
            .acc_sat    (sat_w[i])
        );

        assign bus.next_pixel[i] = np[i];
        assign bus.product[i]    = prod_w[i];
        assign bus.acc_out[i]    = acc_w[i];
        assign bus.acc_sat[i]    = sat_w[i];
    end

endmodule

// File: doc/pe_row_param.md
# pe_row_param

Parametrised successor of the fixed 16-lane mode-12 PE row: a row of `NUM_PE` weight-stationary multiply-accumulate lanes with a run-time pixel-routing mode (direct, cast, systolic shift, cast+shift) on a configurable window of cast-capable lanes. It adds a valid-tagged pipeline, per-lane saturating accumulators and a weight-load strobe. It sits between the DLA pixel/weight buffers and the partial-sum adder tree.

## Interface
- `NUM_PE`, 16, lane count (≥2)
- `DW`, 8, pixel/weight width
- `PW`, 16, product width (= 2·DW)
- `ACC_W`, 24, accumulator width (> PW)
- `CAST_BASE`, 12, first cast-capable lane
- `CAST_NUM`, 3, cast lane count (`CAST_BASE+CAST_NUM ≤ NUM_PE`)

- `clk` in 1 — the single clock
- `rst` in 1 — reset, asynchronous, active-low
- `mode` in 2 — routing mode, sampled with `in_valid`
- `in_valid` in 1 — pixel beat present
- `pixel_in` in `NUM_PE`×DW — per-lane pixels, unsigned
- `pixel_cast` in `CAST_NUM`×DW — broadcast pixels for cast lanes
- `w_load` in 1 — latch `weight_in` into lane weight registers
- `weight_in` in `NUM_PE`×DW — per-lane weights, signed
- `acc_clr` in 1 — with `in_valid`: this beat's product replaces the accumulator
- `next_pixel` out `NUM_PE`×DW — registered selected pixel per lane
- `prod_valid` out 1; `product` out `NUM_PE`×PW signed
- `acc_valid` out 1; `acc_out` out `NUM_PE`×ACC_W signed
- `acc_sat` out `NUM_PE` — sticky per-lane saturation flag

## Operation
- Lane pixel source per mode, lane i, cast index k = i−CAST_BASE:
  - 0 DIRECT: `pixel_in[i]`
  - 1 CAST: cast lanes take `pixel_cast[k]`; others `pixel_in[i]`
  - 2 SHIFT: lane 0 takes `pixel_in[0]`; lane i>0 takes `next_pixel[i-1]` (previous registered value)
  - 3 CAST_SHIFT: cast lanes take `pixel_cast[k]`; others as SHIFT
- Stage 1: on `in_valid`, `next_pixel` ← selected pixel; weight for the beat ← current `weight_q`; `acc_clr` tagged. No `in_valid` → `next_pixel` holds.
- Stage 2: `product` = unsigned pixel × signed weight, exact in PW bits (range −32640..32385 at DW=8); registered with `prod_valid`.
- Stage 3: on `prod_valid`, acc ← (clr ? 0 : acc) + sign-extended product, saturated to signed ACC_W min/max; saturation sets `acc_sat[i]`; tagged clr clears `acc_sat[i]` before this beat's evaluation.
- `w_load`: `weight_q` ← `weight_in` at clock edge; a beat with `in_valid` in the same cycle uses the old weights.
- No backpressure; one beat per cycle sustained.

## Timing
- `in_valid` at edge t → `next_pixel` t+1, `product`/`prod_valid` t+2, `acc_out`/`acc_valid` t+3.
- Valid outputs are single-cycle pulses per beat; data outputs hold between beats.
- Mode change between consecutive beats: each beat routed by its own sampled mode; SHIFT after DIRECT uses the DIRECT-registered `next_pixel`.
- Reset (any time, mid-stream included): all `next_pixel`, `weight_q`, `product`, `acc_out`, `acc_sat` = 0; `prod_valid`, `acc_valid` = 0; in-flight beats dropped. First beat after release needs no flush.

## Structure
- Package `pe_row_pkg`: `pe_mode_e` (DIRECT, CAST, SHIFT, CAST_SHIFT), default widths.
- Sub-module `pe_lane`: one lane (pixel mux input, weight reg, multiplier, product reg, saturating accumulator, sat flag); row generates `NUM_PE` instances and the routing/valid pipeline.

## Test plan
- Reset then `w_load` weights all 3, DIRECT beat pixels i → at t+2 `product[i]`=3i, `prod_valid` one cycle; t+3 `acc_out[i]`=3i with clr.
- CAST beat, `pixel_cast`={10,20,30}, pixels 1, weights 2 → lanes 12..14 product 20,40,60; others 2.
- SHIFT: DIRECT beat pixels i, then SHIFT beat `pixel_in[0]`=99 → `next_pixel` = {99,0,1,…,14}.
- Saturation: weight −128, pixel 255, 300 beats no clr → `acc_out` clamps at −8388608, `acc_sat`=1; next clr beat clears flag.
- `w_load` (weights 5) same cycle as beat with old weights 1, pixel 4 → product 4; following beat product 20.
- Assert `rst` low at t+1 of a beat → outputs 0, no `prod_valid`/`acc_valid` emerges.
